// File: rtl/s_axi_read_banked.sv
// AXI4-Lite read slave that decodes the top address bits into one of NUM_BANKS
// register banks, waits a bounded number of cycles for bank data, and returns it on R.
module s_axi_read_banked #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned BANK_SEL_WIDTH = 2,
  parameter int unsigned OFFSET_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            bank_req,
  output logic [BANK_SEL_WIDTH-1:0]       bank_sel,
  output logic [OFFSET_WIDTH-1:0]         bank_offset,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata,
  input  logic [NUM_BANKS-1:0]            bank_ready,
  output logic [CNT_WIDTH-1:0]            stat_rd_cnt,
  output logic [CNT_WIDTH-1:0]            stat_err_cnt
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                    state, state_nx;
  logic [WAIT_W-1:0]         wait_cnt;
  logic [BANK_SEL_WIDTH-1:0] ar_idx;
  logic                      ar_hit;
  logic                      ar_hs;
  logic                      r_hs;
  logic                      timeout;
  logic                      sel_ready;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      unused_addr;

  assign ar_idx      = S_AXI_ARADDR[ADDR_WIDTH-1 -: BANK_SEL_WIDTH];
  assign ar_hit      = 32'(ar_idx) < NUM_BANKS;
  assign r_hs        = S_AXI_RVALID && S_AXI_RREADY;
  assign timeout     = wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1);
  // Low address bits and the aliased gap below the bank field are intentionally unused.
  assign unused_addr = ^S_AXI_ARADDR;

  // Ready/data of the currently selected bank; other banks' strobes are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (bank_sel == BANK_SEL_WIDTH'(i)) begin
        sel_ready = bank_ready[i];
        sel_data  = bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ar_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          ar_hs    = 1'b1;
          state_nx = ar_hit ? REQ : RESP;
        end
      end
      REQ: begin
        if (sel_ready || timeout) state_nx = RESP;
      end
      RESP: begin
        if (r_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered AXI/bank outputs, response capture and statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      bank_req      <= 1'b0;
      bank_sel      <= '0;
      bank_offset   <= '0;
      wait_cnt      <= '0;
      stat_rd_cnt   <= '0;
      stat_err_cnt  <= '0;
    end else begin
      S_AXI_ARREADY <= state_nx == IDLE;
      S_AXI_RVALID  <= state_nx == RESP;
      bank_req      <= state_nx == REQ;

      if (ar_hs) begin
        bank_sel    <= ar_idx;
        bank_offset <= S_AXI_ARADDR[OFFSET_WIDTH+1:2];
        wait_cnt    <= '0;
        if (!ar_hit) begin
          S_AXI_RDATA <= '0;
          S_AXI_RRESP <= RESP_DECERR;
        end
      end

      // A ready in the final wait cycle wins over the timeout.
      if (state == REQ) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
        if (sel_ready) begin
          S_AXI_RDATA <= sel_data;
          S_AXI_RRESP <= RESP_OKAY;
        end else if (timeout) begin
          S_AXI_RDATA <= '0;
          S_AXI_RRESP <= RESP_SLVERR;
        end
      end

      if (r_hs) begin
        if (stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + CNT_WIDTH'(1);
        if (S_AXI_RRESP != RESP_OKAY && stat_err_cnt != '1)
          stat_err_cnt <= stat_err_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_s_axi_read_banked.sv
// Directed self-checking bench for s_axi_read_banked (3 banks, 2-bit counters).
module tb_s_axi_read_banked;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned NB   = 3;
  localparam int unsigned BSW  = 2;
  localparam int unsigned OW   = 8;
  localparam int unsigned TO   = 64;
  localparam int unsigned CW   = 2;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    araddr;
  logic             arvalid;
  logic             arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic             bank_req;
  logic [BSW-1:0]   bank_sel;
  logic [OW-1:0]    bank_offset;
  logic [NB*DW-1:0] bank_rdata;
  logic [NB-1:0]    bank_ready;
  logic [CW-1:0]    stat_rd_cnt;
  logic [CW-1:0]    stat_err_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned exp_rd  = 0;
  int unsigned exp_err = 0;

  always #5 clk = ~clk;

  s_axi_read_banked #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_SEL_WIDTH(BSW),
    .OFFSET_WIDTH(OW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .bank_req(bank_req), .bank_sel(bank_sel), .bank_offset(bank_offset),
    .bank_rdata(bank_rdata), .bank_ready(bank_ready),
    .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an address and return in the first cycle after the AR handshake.
  task automatic addr_phase(input logic [AW-1:0] a);
    int unsigned t;
    t = 0;
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && t < 20) begin
      step();
      t++;
    end
    check("ar_accept", 32'(arready), 32'd1);
    step();
    arvalid = 1'b0;
  endtask

  task automatic r_handshake(input logic is_err);
    rready = 1'b1;
    step();
    rready = 1'b0;
    if (exp_rd < CMAX) exp_rd++;
    if (is_err && exp_err < CMAX) exp_err++;
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("rd_cnt", 32'(stat_rd_cnt), exp_rd);
    check("err_cnt", 32'(stat_err_cnt), exp_err);
  endtask

  task automatic okay_read(input logic [AW-1:0] a, input int unsigned bank, input int unsigned delay,
                           input logic [DW-1:0] d, input logic [OW-1:0] exp_off);
    addr_phase(a);
    check("req_on", 32'(bank_req), 32'd1);
    check("arready_req", 32'(arready), 32'd0);
    check("bank_sel", 32'(bank_sel), bank);
    check("bank_offset", 32'(bank_offset), 32'(exp_off));
    for (int i = 0; i < int'(delay); i++) step();
    check("rvalid_early", 32'(rvalid), 32'd0);
    bank_ready[bank]            = 1'b1;
    bank_rdata[bank*DW +: DW]   = d;
    step();
    bank_ready = '0;
    bank_rdata = '0;
    check("rvalid_ok", 32'(rvalid), 32'd1);
    check("rdata_ok", rdata, d);
    check("rresp_ok", 32'(rresp), 32'd0);
    check("req_off", 32'(bank_req), 32'd0);
    r_handshake(1'b0);
  endtask

  task automatic decerr_read(input logic [AW-1:0] a);
    addr_phase(a);
    check("decerr_req", 32'(bank_req), 32'd0);
    check("decerr_rvalid", 32'(rvalid), 32'd1);
    check("decerr_rresp", 32'(rresp), 32'd3);
    check("decerr_rdata", rdata, 32'd0);
    r_handshake(1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned cnt;
    reset      = 1'b0;
    arvalid    = 1'b1;
    araddr     = 16'h4010;
    rready     = 1'b0;
    bank_ready = '0;
    bank_rdata = '0;
    repeat (3) step();
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_req", 32'(bank_req), 32'd0);
    check("rst_rd_cnt", 32'(stat_rd_cnt), 32'd0);
    check("rst_err_cnt", 32'(stat_err_cnt), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset   = 1'b1;
    arvalid = 1'b0;
    step();
    check("post_rst_arready", 32'(arready), 32'd1);

    // Bank 1, offset 4, data two cycles after request.
    okay_read(16'h4010, 1, 2, 32'hDEADBEEF, 8'd4);

    // R backpressure with a competing ARVALID that must not be accepted.
    addr_phase(16'h4020);
    check("bp_offset", 32'(bank_offset), 32'd8);
    bank_ready[1]      = 1'b1;
    bank_rdata[63:32]  = 32'hCAFEF00D;
    step();
    bank_ready = '0;
    bank_rdata = '0;
    araddr     = 16'h0000;
    arvalid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_rdata", rdata, 32'hCAFEF00D);
      check("bp_rresp", 32'(rresp), 32'd0);
      check("bp_arready", 32'(arready), 32'd0);
      step();
    end
    arvalid = 1'b0;
    r_handshake(1'b0);
    step();
    check("bp_single_hs", 32'(rvalid), 32'd0);
    check("bp_rd_cnt", 32'(stat_rd_cnt), exp_rd);

    // Bank never ready: request held exactly TO cycles then SLVERR.
    addr_phase(16'h8000);
    cnt = 0;
    while (bank_req && cnt < 200) begin
      cnt++;
      step();
    end
    check("to_req_cycles", cnt, TO);
    check("to_rvalid", 32'(rvalid), 32'd1);
    check("to_rresp", 32'(rresp), 32'd2);
    check("to_rdata", rdata, 32'd0);
    r_handshake(1'b1);

    // Ready in the final allowed cycle wins.
    addr_phase(16'h8004);
    repeat (TO - 1) step();
    check("last_req", 32'(bank_req), 32'd1);
    check("last_rvalid", 32'(rvalid), 32'd0);
    bank_ready[2]     = 1'b1;
    bank_rdata[95:64] = 32'h12345678;
    step();
    bank_ready = '0;
    bank_rdata = '0;
    check("last_rvalid_ok", 32'(rvalid), 32'd1);
    check("last_rresp", 32'(rresp), 32'd0);
    check("last_rdata", rdata, 32'h12345678);
    r_handshake(1'b0);

    // Bank index 3 with only 3 banks.
    decerr_read(16'hC000);

    // Strobe from a non-selected bank is ignored.
    addr_phase(16'h8008);
    check("wb_sel", 32'(bank_sel), 32'd2);
    check("wb_offset", 32'(bank_offset), 32'd2);
    bank_ready       = 3'b001;
    bank_rdata[31:0] = 32'h11111111;
    step();
    bank_ready = '0;
    bank_rdata = '0;
    check("wb_rvalid", 32'(rvalid), 32'd0);
    check("wb_req", 32'(bank_req), 32'd1);
    bank_ready[2]     = 1'b1;
    bank_rdata[95:64] = 32'h22222222;
    step();
    bank_ready = '0;
    bank_rdata = '0;
    check("wb_rdata", rdata, 32'h22222222);
    check("wb_rresp", 32'(rresp), 32'd0);
    r_handshake(1'b0);

    // Reset during REQ abandons the transaction.
    addr_phase(16'h4000);
    step();
    check("mr_req", 32'(bank_req), 32'd1);
    reset = 1'b0;
    step();
    exp_rd  = 0;
    exp_err = 0;
    check("mr_req_off", 32'(bank_req), 32'd0);
    check("mr_rvalid", 32'(rvalid), 32'd0);
    check("mr_arready", 32'(arready), 32'd0);
    check("mr_rd_cnt", 32'(stat_rd_cnt), 32'd0);
    check("mr_err_cnt", 32'(stat_err_cnt), 32'd0);
    reset = 1'b1;
    step();
    check("mr_arready_back", 32'(arready), 32'd1);
    repeat (3) begin
      check("mr_no_rvalid", 32'(rvalid), 32'd0);
      step();
    end

    // Five reads saturate the 2-bit read counter; misaligned/aliased address included.
    okay_read(16'h4413, 1, 0, 32'hA5A5A5A5, 8'd4);
    okay_read(16'h0000, 0, 1, 32'h0F0F0F0F, 8'd0);
    decerr_read(16'hC000);
    decerr_read(16'hFFFC);
    okay_read(16'h8010, 2, 0, 32'h13572468, 8'd4);
    check("rd_sat", 32'(stat_rd_cnt), 32'd3);
    decerr_read(16'hC004);
    decerr_read(16'hC008);
    check("err_sat", 32'(stat_err_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
